// File: rtl/can_pkg.sv
// Shared definitions for the CAN receive destuffing sequencer: state encoding,
// frame field positions (indices count destuffed bits, SOF = 0) and the
// helper that derives the last stuffed bit index from the control field.
package can_pkg;

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_STUFF     = 2'd2,
    ST_TAIL      = 2'd3
  } can_state_e;

  localparam logic [2:0] STUFF_LIMIT  = 3'd5;
  localparam int         CRC_LEN      = 15;
  localparam int         TAIL_LEN     = 10;

  localparam logic [6:0] RTR_IDX_STD  = 7'd12;
  localparam logic [6:0] IDE_IDX      = 7'd13;
  localparam logic [6:0] DLC_IDX_STD  = 7'd15;
  localparam logic [6:0] DLC_END_STD  = DLC_IDX_STD + 7'd3;
  localparam logic [6:0] DATA_IDX_STD = 7'd19;

  localparam logic [6:0] RTR_IDX_EXT  = 7'd32;
  localparam logic [6:0] DLC_IDX_EXT  = 7'd35;
  localparam logic [6:0] DLC_END_EXT  = DLC_IDX_EXT + 7'd3;
  localparam logic [6:0] DATA_IDX_EXT = 7'd39;

  localparam logic [6:0] CRC_LAST_OFS = 7'(CRC_LEN - 1);
  localparam logic [6:0] TAIL_OFS     = 7'(TAIL_LEN);

  // Index of the last CRC bit: data start + 8 * clamped byte count + 14.
  function automatic logic [6:0] calc_last_idx(input logic [3:0] dlc,
                                               input logic       rtr,
                                               input logic [6:0] data_start);
    logic [3:0] nbytes;
    nbytes = rtr ? 4'd0 : ((dlc > 4'd8) ? 4'd8 : dlc);
    return data_start + {nbytes[3:0], 3'b000} + CRC_LAST_OFS;
  endfunction

endpackage

// File: rtl/can_run_tracker.sv
// Run-length tracker for the stuffed region: counts equal consecutive bits
// (stuff bits included) and tells the sequencer when the next bit must be a
// stuff bit, whether it violates the stuffing rule, and whether the current
// bit completes a run of STUFF_LIMIT.
module can_run_tracker
  import can_pkg::*;
(
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic clear,
  input  logic start,
  input  logic shift,
  input  logic bit_in,
  output logic stuff_expected,
  output logic stuff_error,
  output logic limit_next
);

  logic [2:0] run_len;
  logic       last_val;
  logic [2:0] run_inc;

  // Next run length for the incoming bit and the stuff decisions derived from it.
  always_comb begin
    run_inc        = (bit_in == last_val) ? run_len + 3'd1 : 3'd1;
    stuff_expected = (run_len == STUFF_LIMIT);
    stuff_error    = stuff_expected && (bit_in == last_val);
    limit_next     = (run_inc == STUFF_LIMIT);
  end

  // Run state: SOF seeds a dominant run of one, every stuffed-region bit updates it.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || clear) begin
      run_len  <= 3'd0;
      last_val <= 1'b1;
    end else if (start) begin
      run_len  <= 3'd1;
      last_val <= 1'b0;
    end else if (shift) begin
      run_len  <= run_inc;
      last_val <= bit_in;
    end
  end

endmodule

// File: rtl/can_destuff_ctrl.sv
// CAN receive destuffing sequencer: bus integration, SOF detection, stuff bit
// removal from SOF through the last CRC bit, fixed-form checks on the frame
// tail, and a destuffed bit stream with frame bit index.
// Optional feature macro: CAN_DESTUFF_EXT_EN (extended 29-bit ID layout);
// without it an IDE = 1 frame is rejected with a form error.
module can_destuff_ctrl
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Bit_Valid,
  input  logic       i_Bit,
  input  logic       i_Frame_Abort,
  output logic       o_Data_Valid,
  output logic       o_Data_Bit,
  output logic [6:0] o_Bit_Index,
  output logic       o_Stuff_Error,
  output logic       o_Form_Error,
  output logic       o_Frame_Done,
  output logic       o_Busy
);

  localparam int CNT_W = $clog2(IDLE_BITS + 1);
  localparam logic [CNT_W-1:0] INTEG_LAST = CNT_W'(IDLE_BITS - 1);

  can_state_e       state;
  logic [CNT_W-1:0] integ_cnt;
  logic [6:0]       nxt_idx;
  logic [6:0]       last_idx;
  logic [3:0]       dlc;
  logic             rtr;
  logic             crc_end;
`ifdef CAN_DESTUFF_EXT_EN
  logic             ide;
`endif

  logic stuff_expected, stuff_error, limit_next;
  logic trk_start, trk_shift;
  logic ide_reject;
  logic [6:0] ack_idx, end_idx;

  can_run_tracker u_run (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .clear          (i_Frame_Abort),
    .start          (trk_start),
    .shift          (trk_shift),
    .bit_in         (i_Bit),
    .stuff_expected (stuff_expected),
    .stuff_error    (stuff_error),
    .limit_next     (limit_next)
  );

  // Tracker strobes, tail positions and the IDE acceptance rule.
  always_comb begin
    trk_start = i_Bit_Valid && (state == ST_IDLE) && !i_Bit;
    trk_shift = i_Bit_Valid && (state == ST_STUFF);
    ack_idx   = last_idx + 7'd2;
    end_idx   = last_idx + TAIL_OFS;
`ifdef CAN_DESTUFF_EXT_EN
    ide_reject = 1'b0;
`else
    ide_reject = (nxt_idx == IDE_IDX) && i_Bit;
`endif
  end

  // Sequencer: integration, SOF, stuffed region, tail, with registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state         <= ST_INTEGRATE;
      integ_cnt     <= '0;
      nxt_idx       <= 7'd0;
      last_idx      <= 7'd127;
      crc_end       <= 1'b0;
      o_Data_Valid  <= 1'b0;
      o_Data_Bit    <= 1'b0;
      o_Bit_Index   <= 7'd0;
      o_Stuff_Error <= 1'b0;
      o_Form_Error  <= 1'b0;
      o_Frame_Done  <= 1'b0;
      o_Busy        <= 1'b0;
    end else begin
      o_Data_Valid  <= 1'b0;
      o_Stuff_Error <= 1'b0;
      o_Form_Error  <= 1'b0;
      o_Frame_Done  <= 1'b0;
      if (i_Frame_Abort) begin
        state       <= ST_INTEGRATE;
        integ_cnt   <= '0;
        nxt_idx     <= 7'd0;
        o_Bit_Index <= 7'd0;
        crc_end     <= 1'b0;
        o_Busy      <= 1'b0;
      end else if (i_Bit_Valid) begin
        case (state)
          ST_INTEGRATE: begin
            if (!i_Bit) begin
              integ_cnt <= '0;
            end else if (integ_cnt == INTEG_LAST) begin
              integ_cnt <= '0;
              state     <= ST_IDLE;
            end else begin
              integ_cnt <= integ_cnt + 1'b1;
            end
          end
          ST_IDLE: begin
            if (!i_Bit) begin
              o_Data_Valid <= 1'b1;
              o_Data_Bit   <= 1'b0;
              o_Bit_Index  <= 7'd0;
              o_Busy       <= 1'b1;
              nxt_idx      <= 7'd1;
              last_idx     <= 7'd127;
              crc_end      <= 1'b0;
              state        <= ST_STUFF;
            end
          end
          ST_STUFF: begin
            if (stuff_expected) begin
              if (stuff_error) begin
                o_Stuff_Error <= 1'b1;
                o_Busy        <= 1'b0;
                integ_cnt     <= '0;
                crc_end       <= 1'b0;
                state         <= ST_INTEGRATE;
              end else if (crc_end) begin
                crc_end <= 1'b0;
                state   <= ST_TAIL;
              end
            end else if (ide_reject) begin
              o_Form_Error <= 1'b1;
              o_Busy       <= 1'b0;
              integ_cnt    <= '0;
              state        <= ST_INTEGRATE;
            end else begin
              o_Data_Valid <= 1'b1;
              o_Data_Bit   <= i_Bit;
              o_Bit_Index  <= nxt_idx;
              nxt_idx      <= nxt_idx + 7'd1;
              dlc          <= {dlc[2:0], i_Bit};
              if (nxt_idx == RTR_IDX_STD) rtr <= i_Bit;
`ifdef CAN_DESTUFF_EXT_EN
              if (nxt_idx == IDE_IDX) ide <= i_Bit;
              if (ide && nxt_idx == RTR_IDX_EXT) rtr <= i_Bit;
              if (!ide && nxt_idx == DLC_END_STD)
                last_idx <= calc_last_idx({dlc[2:0], i_Bit}, rtr, DATA_IDX_STD);
              if (ide && nxt_idx == DLC_END_EXT)
                last_idx <= calc_last_idx({dlc[2:0], i_Bit}, rtr, DATA_IDX_EXT);
`else
              if (nxt_idx == DLC_END_STD)
                last_idx <= calc_last_idx({dlc[2:0], i_Bit}, rtr, DATA_IDX_STD);
`endif
              // A run completed by the last CRC bit still owes a stuff bit.
              if (nxt_idx == last_idx) begin
                if (limit_next) crc_end <= 1'b1;
                else            state   <= ST_TAIL;
              end
            end
          end
          ST_TAIL: begin
            if (!i_Bit && nxt_idx != ack_idx) begin
              o_Form_Error <= 1'b1;
              o_Busy       <= 1'b0;
              integ_cnt    <= '0;
              state        <= ST_INTEGRATE;
            end else begin
              o_Data_Valid <= 1'b1;
              o_Data_Bit   <= i_Bit;
              o_Bit_Index  <= nxt_idx;
              nxt_idx      <= nxt_idx + 7'd1;
              if (nxt_idx == end_idx) begin
                o_Frame_Done <= 1'b1;
                o_Busy       <= 1'b0;
                state        <= ST_IDLE;
              end
            end
          end
          default: state <= ST_INTEGRATE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_destuff_ctrl.sv
// Directed bench for can_destuff_ctrl: integration and SOF, stuff bit removal,
// stuff errors, complete standard frames, tail form errors, abort and IDE.
module tb_can_destuff_ctrl;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Bit_Valid = 1'b0;
  logic       i_Bit = 1'b1;
  logic       i_Frame_Abort = 1'b0;
  logic       o_Data_Valid, o_Data_Bit, o_Stuff_Error, o_Form_Error, o_Frame_Done, o_Busy;
  logic [6:0] o_Bit_Index;

  can_destuff_ctrl #(.IDLE_BITS(11)) dut (
    .i_Clock       (i_Clock),
    .i_Reset       (i_Reset),
    .i_Bit_Valid   (i_Bit_Valid),
    .i_Bit         (i_Bit),
    .i_Frame_Abort (i_Frame_Abort),
    .o_Data_Valid  (o_Data_Valid),
    .o_Data_Bit    (o_Data_Bit),
    .o_Bit_Index   (o_Bit_Index),
    .o_Stuff_Error (o_Stuff_Error),
    .o_Form_Error  (o_Form_Error),
    .o_Frame_Done  (o_Frame_Done),
    .o_Busy        (o_Busy)
  );

  always #5 i_Clock = ~i_Clock;

  int n_vec = 0;
  int n_err = 0;

  logic       s_dv, s_db, s_se, s_fe, s_fd, s_busy;
  logic [6:0] s_idx;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample();
    s_dv = o_Data_Valid; s_db = o_Data_Bit; s_idx = o_Bit_Index;
    s_se = o_Stuff_Error; s_fe = o_Form_Error; s_fd = o_Frame_Done; s_busy = o_Busy;
  endtask

  task automatic strobe(input logic b);
    @(negedge i_Clock);
    i_Reset = 1'b0; i_Frame_Abort = 1'b0; i_Bit_Valid = 1'b1; i_Bit = b;
    @(posedge i_Clock); #1;
    sample();
  endtask

  task automatic idle_cycle();
    @(negedge i_Clock);
    i_Frame_Abort = 1'b0; i_Bit_Valid = 1'b0;
    @(posedge i_Clock); #1;
    sample();
  endtask

  task automatic abort_cycle(input logic b);
    @(negedge i_Clock);
    i_Frame_Abort = 1'b1; i_Bit_Valid = 1'b1; i_Bit = b;
    @(posedge i_Clock); #1;
    sample();
  endtask

  task automatic integrate();
    for (int i = 0; i < 11; i++) strobe(1'b1);
  endtask

  // Unstuffed frame image and results of the last transmission.
  logic ub [0:127];
  int   ulen, lidx;
  int   r_dv, r_bad, r_stuff_bad, r_se, r_fe, r_fe_pos, r_fd, r_fd_idx;
  logic r_abort_pulse, r_abort_busy;

  task automatic build_frame(input logic [10:0] id, input logic ide, input logic rtr,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input logic ack, input logic ack_delim);
    int p, nb;
    logic [17:0] idb;
    logic [14:0] crc;
    idb = 18'h2A5C3;
    crc = 15'h4D2B;
    p = 0;
    ub[p] = 1'b0; p++;
    for (int i = 10; i >= 0; i--) begin ub[p] = id[i]; p++; end
    if (ide) begin
      ub[p] = 1'b1; p++;
      ub[p] = 1'b1; p++;
      for (int i = 17; i >= 0; i--) begin ub[p] = idb[i]; p++; end
      ub[p] = rtr; p++;
      ub[p] = 1'b0; p++;
      ub[p] = 1'b0; p++;
    end else begin
      ub[p] = rtr; p++;
      ub[p] = 1'b0; p++;
      ub[p] = 1'b0; p++;
    end
    for (int i = 3; i >= 0; i--) begin ub[p] = dlc[i]; p++; end
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < 8 * nb; i++) begin ub[p] = data[63 - i]; p++; end
    for (int i = 14; i >= 0; i--) begin ub[p] = crc[i]; p++; end
    lidx = p - 1;
    ub[p] = 1'b1; p++;
    ub[p] = ack; p++;
    ub[p] = ack_delim; p++;
    for (int i = 0; i < 7; i++) begin ub[p] = 1'b1; p++; end
    ulen = p;
  endtask

  task automatic note(input int u);
    if (s_dv) begin
      r_dv++;
      if (s_idx != 7'(u) || s_db != ub[u]) r_bad++;
    end
    if (s_se) r_se++;
    if (s_fe) begin r_fe++; r_fe_pos = u; end
    if (s_fd) begin r_fd++; r_fd_idx = int'(s_idx); end
  endtask

  // Transmit the frame image with stuff bits inserted from SOF to the last CRC bit.
  task automatic send_frame(input int abort_at);
    int run;
    logic last, sb;
    r_dv = 0; r_bad = 0; r_stuff_bad = 0; r_se = 0; r_fe = 0; r_fe_pos = -1;
    r_fd = 0; r_fd_idx = -1; r_abort_pulse = 1'b0; r_abort_busy = 1'b1;
    run = 0; last = 1'b1;
    for (int u = 0; u < ulen; u++) begin
      if (u == abort_at) begin
        abort_cycle(ub[u]);
        r_abort_pulse = s_dv | s_se | s_fe | s_fd;
        r_abort_busy = s_busy;
        break;
      end
      strobe(ub[u]);
      note(u);
      if (s_se || s_fe) break;
      if (u <= lidx) begin
        if (u > 0 && ub[u] == last) run++;
        else run = 1;
        last = ub[u];
        if (run == 5) begin
          sb = ~last;
          strobe(sb);
          if (s_dv || s_se || s_fe || s_fd) r_stuff_bad++;
          run = 1;
          last = sb;
        end
      end
    end
  endtask

  int cnt;

  initial begin
    repeat (3) @(posedge i_Clock);
    #1;
    sample();
    check_val("rst_dv", s_dv, 0);
    check_val("rst_idx", s_idx, 0);
    check_val("rst_busy", s_busy, 0);
    check_val("rst_pulses", {s_se, s_fe, s_fd, s_db}, 0);

    // Integration then SOF
    integrate();
    check_val("integ_busy", s_busy, 0);
    strobe(1'b0);
    check_val("sof_busy", s_busy, 1);
    check_val("sof_dv", s_dv, 1);
    check_val("sof_bit", s_db, 0);
    check_val("sof_idx", s_idx, 0);

    // Four more dominant bits, then the stuff bit is dropped
    for (int i = 0; i < 4; i++) strobe(1'b0);
    check_val("id4_idx", s_idx, 4);
    strobe(1'b1);
    check_val("stuff_no_dv", s_dv, 0);
    check_val("stuff_idx_held", s_idx, 4);
    strobe(1'b0);
    check_val("after_stuff_dv", s_dv, 1);
    check_val("after_stuff_idx", s_idx, 5);
    abort_cycle(1'b0);
    check_val("abort1_busy", s_busy, 0);

    // Six equal dominant bits give one stuff error
    integrate();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin strobe(1'b0); if (s_se) cnt++; end
    check_val("stuff_err_cnt", cnt, 1);
    check_val("stuff_err_last", s_se, 1);
    check_val("stuff_err_busy", s_busy, 0);
    idle_cycle();
    check_val("stuff_err_pulse_len", s_se, 0);
    for (int i = 0; i < 5; i++) strobe(1'b1);
    strobe(1'b0);
    check_val("early_sof_ignored", s_dv, 0);
    check_val("early_sof_busy", s_busy, 0);

    // Standard frame, DLC 1, data 0xAA
    integrate();
    build_frame(11'h123, 1'b0, 1'b0, 4'd1, 64'hAA00_0000_0000_0000, 1'b0, 1'b1);
    send_frame(-1);
    check_val("f1_done_cnt", r_fd, 1);
    check_val("f1_done_idx", r_fd_idx, 51);
    check_val("f1_dv_cnt", r_dv, 52);
    check_val("f1_bits", r_bad, 0);
    check_val("f1_stuff_quiet", r_stuff_bad, 0);
    check_val("f1_errors", r_se + r_fe, 0);
    check_val("f1_busy_end", s_busy, 0);

    // DLC 15 clamps to 8 bytes; follows directly from IDLE, recessive ACK
    idle_cycle();
    build_frame(11'h7F0, 1'b0, 1'b0, 4'd15, 64'h0000_FFFF_0F0F_5533, 1'b1, 1'b1);
    send_frame(-1);
    check_val("f2_done_cnt", r_fd, 1);
    check_val("f2_done_idx", r_fd_idx, 107);
    check_val("f2_dv_cnt", r_dv, 108);
    check_val("f2_bits", r_bad, 0);
    check_val("f2_stuff_quiet", r_stuff_bad, 0);
    check_val("f2_errors", r_se + r_fe, 0);

    // Dominant ACK delimiter
    integrate();
    build_frame(11'h555, 1'b0, 1'b0, 4'd0, 64'h0, 1'b0, 1'b0);
    send_frame(-1);
    check_val("f3_form_cnt", r_fe, 1);
    check_val("f3_form_pos", r_fe_pos, 36);
    check_val("f3_no_done", r_fd, 0);
    check_val("f3_busy", s_busy, 0);

    // Abort at index 20
    integrate();
    build_frame(11'h3C5, 1'b0, 1'b0, 4'd2, 64'h1234_0000_0000_0000, 1'b0, 1'b1);
    send_frame(20);
    check_val("f4_abort_pulses", r_abort_pulse, 0);
    check_val("f4_abort_busy", r_abort_busy, 0);
    check_val("f4_dv_cnt", r_dv, 20);
    check_val("f4_no_flags", r_se + r_fe + r_fd, 0);
    strobe(1'b0);
    check_val("f4_integrate_sof", s_dv, 0);

    // IDE = 1
    integrate();
    build_frame(11'h0F0, 1'b1, 1'b0, 4'd0, 64'h0, 1'b0, 1'b1);
    send_frame(-1);
`ifdef CAN_DESTUFF_EXT_EN
    check_val("f5_done_cnt", r_fd, 1);
    check_val("f5_done_idx", r_fd_idx, 63);
    check_val("f5_bits", r_bad, 0);
    check_val("f5_errors", r_se + r_fe, 0);
`else
    check_val("f5_form_cnt", r_fe, 1);
    check_val("f5_form_pos", r_fe_pos, 13);
    check_val("f5_dv_cnt", r_dv, 13);
    check_val("f5_busy", s_busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/can_destuff_ctrl.md
# can_destuff_ctrl

Receive-side sequencer for the CAN bit-destuffing datapath. It consumes one sampled bus bit per sample-point strobe, and tracks bus-idle integration and the frame field position. It enables destuffing only from SOF through the last CRC bit, drops stuff bits, and flags stuff and form errors. It sits between the bit-timing/sampling logic and the CAN receive shift register, and feeds it a clean destuffed bit stream with a bit index.

## Interface
- IDLE_BITS, 11, consecutive recessive bits needed before a SOF is accepted (bus integration)
- i_Clock  in  1  system clock, all logic on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Bit_Valid  in  1  one-cycle strobe at the sample point
- i_Bit  in  1  sampled bus level (0 = dominant); qualified by i_Bit_Valid
- i_Frame_Abort  in  1  synchronous abort request from the receive controller
- o_Data_Valid  out  1  one-cycle pulse, destuffed frame bit on o_Data_Bit
- o_Data_Bit  out  1  destuffed bit
- o_Bit_Index  out  7  frame position of o_Data_Bit; SOF = 0; stuff bits excluded
- o_Stuff_Error  out  1  one-cycle pulse, 6th equal bit seen in the stuffed region
- o_Form_Error  out  1  one-cycle pulse, fixed-form bit wrong or unsupported IDE
- o_Frame_Done  out  1  one-cycle pulse after the last EOF bit
- o_Busy  out  1  high from SOF until done or error

## Operation
- States:
  - INTEGRATE: count recessive bits; a dominant bit clears the count; at IDLE_BITS go to IDLE.
  - IDLE: dominant bit = SOF, go to STUFF with index 0, run value 0, run length 1.
  - STUFF: stuffed region.
  - TAIL: CRC delimiter, ACK slot, ACK delimiter, EOF.
- Run tracking in STUFF uses a 3-bit run length and the last value. A bit equal to the last value increments the run; a different bit sets run = 1. Stuff bits are included in the run.
- When run = 5, the next strobe is the stuff bit.
  - Opposite level: dropped (no o_Data_Valid, index held); run = 1, value = stuff bit.
  - Same level: o_Stuff_Error, go to INTEGRATE.
- Standard layout: 1–11 ID, 12 RTR, 13 IDE, 14 r0, 15–18 DLC (MSB first), data from 19. CRC is 15 bits after the data.
- N = data bytes = 0 if RTR = 1, else min(DLC, 8). Last stuffed index L = 33 + 8N.
- After the bit at index L is processed, a pending stuff bit (run = 5) is still checked. Then go to TAIL.
- TAIL: 10 bits, indices L+1..L+10, output unstuffed.
  - CRC delimiter, ACK delimiter and all 7 EOF bits must be 1; a 0 gives o_Form_Error and goes to INTEGRATE.
  - ACK slot accepts either level.
  - After index L+10: o_Frame_Done, go to IDLE (bus integration is not repeated).
- IDE = 1 without the extension feature: o_Form_Error at index 13, go to INTEGRATE.
- i_Frame_Abort: go to INTEGRATE, clear all counters, no pulse outputs. Abort wins over a simultaneous i_Bit_Valid, and that bit is discarded.
- Priority: i_Reset > i_Frame_Abort > bit processing.

## Timing
- Reset values:
  - State INTEGRATE, integration count 0.
  - Run length 0, last value 1.
  - All outputs 0, o_Bit_Index 0.
- All outputs are registered and appear the cycle after the i_Bit_Valid strobe (latency 1).
- Pulse outputs last exactly one cycle. At most one of o_Data_Valid / error pulse / o_Frame_Done is asserted per strobe, except that o_Frame_Done coincides with o_Data_Valid of index L+10.
- o_Bit_Index holds between strobes. The maximum value is 127, so no wrap.
- o_Busy rises with the SOF o_Data_Valid. It falls in the same cycle as o_Frame_Done, an error pulse, or abort + 1.
- Back-to-back strobes on consecutive cycles must be supported.

## Configuration
- CAN_DESTUFF_EXT_EN defined: IDE = 1 selects the extended layout.
  - 12 SRR, 13 IDE, 14–31 ID-B, 32 RTR, 33 r1, 34 r0, 35–38 DLC, data from 39.
  - L = 53 + 8N.
- CAN_DESTUFF_EXT_EN undefined: IDE = 1 is a form error (see Operation). No extended-layout logic is built.

## Structure
- can_pkg holds:
  - state encoding
  - field index constants (IDE_IDX, DLC_IDX_STD/EXT, CRC_LEN = 15, TAIL_LEN = 10)
  - STUFF_LIMIT = 5
- Sub-module can_run_tracker holds the run length, last value, stuff-expected and stuff-error logic. The top level holds the state machine, index and DLC capture.

## Test plan
- Reset, 11 × 1, then 0 -> o_Busy = 1; o_Data_Valid with o_Data_Bit = 0, o_Bit_Index = 0.
- Five 0s (SOF + ID 0x000 start) then a stuff 1 -> stuff bit produces no o_Data_Valid, and the next bit gets index 5.
- Six equal 0s in the ID field -> o_Stuff_Error once; o_Busy = 0; a SOF before 11 recessive bits is ignored.
- Standard frame, DLC = 1, data 0xAA, correctly stuffed -> L = 41; o_Frame_Done with index 51.
- DLC = 15 -> N clamped to 8, o_Frame_Done at index 107.
- Each of the following, run as a separate frame:
  - 0 in the ACK delimiter -> o_Form_Error.
  - i_Frame_Abort at index 20 -> no pulses, INTEGRATE.
  - IDE = 1 -> o_Form_Error at index 13 without the macro; with it, an extended DLC = 0 frame finishes at index 63.
